// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared constants, decoded-register struct and field decode helper.
package y86_pkg;

  localparam int DATA_W = 64;
  localparam int NREG   = 15;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } dec_t;

  // cmov shares rrmovq's icode; its condition is applied at writeback, so dst_e is unconditional here.
  function automatic dec_t decode_fields(input logic [3:0] icode, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rsp);
    dec_t d;
    d = '{src_a: REG_NONE, src_b: REG_NONE, dst_e: REG_NONE, dst_m: REG_NONE};
    case (icode)
      I_RRMOVQ: begin d.src_a = ra;  d.dst_e = rb; end
      I_IRMOVQ: begin d.dst_e = rb; end
      I_RMMOVQ: begin d.src_a = ra;  d.src_b = rb; end
      I_MRMOVQ: begin d.src_b = rb;  d.dst_m = ra; end
      I_OPQ:    begin d.src_a = ra;  d.src_b = rb; d.dst_e = rb; end
      I_CALL:   begin d.src_b = rsp; d.dst_e = rsp; end
      I_RET:    begin d.src_a = rsp; d.src_b = rsp; d.dst_e = rsp; end
      I_PUSHQ:  begin d.src_a = ra;  d.src_b = rsp; d.dst_e = rsp; end
      I_POPQ:   begin d.src_a = rsp; d.src_b = rsp; d.dst_e = rsp; d.dst_m = ra; end
      default:  ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// rtl/regfile_2r2w.sv - NREG x DATA_W register file, 2 async reads, 2 sync writes (M port wins).
// WB_BYPASS_EN: reads see same-cycle write data (M over E); otherwise reads return stored values.
module regfile_2r2w #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [3:0]        rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              wr_e_en,
  input  logic [3:0]        wr_e_addr,
  input  logic [DATA_W-1:0] wr_e_data,
  input  logic              wr_m_en,
  input  logic [3:0]        wr_m_addr,
  input  logic [DATA_W-1:0] wr_m_data
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic              we_e, we_m;

  function automatic logic in_range(input logic [3:0] a);
    return int'(a) < NREG;
  endfunction

  assign we_e = wr_e_en && in_range(wr_e_addr);
  assign we_m = wr_m_en && in_range(wr_m_addr);

  function automatic logic [DATA_W-1:0] rd_port(input logic [3:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (in_range(a)) begin
`ifdef WB_BYPASS_EN
      if (we_m && wr_m_addr == a)      v = wr_m_data;
      else if (we_e && wr_e_addr == a) v = wr_e_data;
      else                             v = regs_q[a];
`else
      v = regs_q[a];
`endif
    end
    return v;
  endfunction

  assign rd_a_data = rd_port(rd_a_addr);
  assign rd_b_data = rd_port(rd_b_addr);

  // M write is issued last so it overrides E on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      if (we_e) regs_q[wr_e_addr] <= wr_e_data;
      if (we_m) regs_q[wr_m_addr] <= wr_m_data;
    end
  end

endmodule

// File: rtl/decode_regread.sv
// rtl/decode_regread.sv - Y86-64 decode: src/dst selection, operand read, ready/valid D->E slot.
// Optional same-cycle writeback bypass selected by WB_BYPASS_EN (in regfile_2r2w).
module decode_regread
  import y86_pkg::*;
#(
  parameter int         DATA_W  = y86_pkg::DATA_W,
  parameter int         NREG    = y86_pkg::NREG,
  parameter logic [3:0] RSP_IDX = REG_RSP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_rA,
  input  logic [3:0]        in_rB,
  input  logic              wr_e_en,
  input  logic [3:0]        wr_e_addr,
  input  logic [DATA_W-1:0] wr_e_data,
  input  logic              wr_m_en,
  input  logic [3:0]        wr_m_addr,
  input  logic [DATA_W-1:0] wr_m_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_icode,
  output logic [DATA_W-1:0] out_valA,
  output logic [DATA_W-1:0] out_valB,
  output logic [3:0]        out_dstE,
  output logic [3:0]        out_dstM
);

  dec_t              dec;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              accept;

  logic              valid_q, valid_d;
  logic [3:0]        icode_q, icode_d;
  logic [DATA_W-1:0] val_a_q, val_a_d;
  logic [DATA_W-1:0] val_b_q, val_b_d;
  logic [3:0]        dst_e_q, dst_e_d;
  logic [3:0]        dst_m_q, dst_m_d;

  assign dec = decode_fields(in_icode, in_rA, in_rB, RSP_IDX);

  regfile_2r2w #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_a_addr (dec.src_a),
    .rd_a_data (rd_a),
    .rd_b_addr (dec.src_b),
    .rd_b_data (rd_b),
    .wr_e_en   (wr_e_en),
    .wr_e_addr (wr_e_addr),
    .wr_e_data (wr_e_data),
    .wr_m_en   (wr_m_en),
    .wr_m_addr (wr_m_addr),
    .wr_m_data (wr_m_data)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Operands are sampled only on accept, so a stalled slot never sees later writebacks.
  always_comb begin
    valid_d = valid_q;
    icode_d = icode_q;
    val_a_d = val_a_q;
    val_b_d = val_b_q;
    dst_e_d = dst_e_q;
    dst_m_d = dst_m_q;
    if (accept) begin
      valid_d = 1'b1;
      icode_d = in_icode;
      val_a_d = rd_a;
      val_b_d = rd_b;
      dst_e_d = dec.dst_e;
      dst_m_d = dec.dst_m;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      icode_q <= 4'h0;
      val_a_q <= '0;
      val_b_q <= '0;
      dst_e_q <= REG_NONE;
      dst_m_q <= REG_NONE;
    end else begin
      valid_q <= valid_d;
      icode_q <= icode_d;
      val_a_q <= val_a_d;
      val_b_q <= val_b_d;
      dst_e_q <= dst_e_d;
      dst_m_q <= dst_m_d;
    end
  end

  assign out_valid = valid_q;
  assign out_icode = icode_q;
  assign out_valA  = val_a_q;
  assign out_valB  = val_b_q;
  assign out_dstE  = dst_e_q;
  assign out_dstM  = dst_m_q;

endmodule
